// File: rtl/ofdm_cp_sequencer.sv
// Cyclic-prefix insertion controller: banks input symbols into a 2-bank external RAM
// and replays each full bank as CP_LEN tail words followed by the whole symbol.
module ofdm_cp_sequencer #(
    parameter int unsigned N_FFT   = 1024,
    parameter int unsigned CP_LEN  = 128,
    parameter int unsigned ADDR_W  = 10,
    parameter int unsigned RAM_LAT = 2
) (
    input  logic              clock_clk,
    input  logic              reset_reset,
    input  logic              asi_in0_valid,
    input  logic              asi_in0_startofpacket,
    input  logic              asi_in0_endofpacket,
    output logic              asi_in0_ready,
    output logic              ram_wr_en,
    output logic [ADDR_W:0]   ram_wr_addr,
    output logic [ADDR_W:0]   ram_rd_addr,
    output logic              ram_rd_ce,
    input  logic              aso_out0_ready,
    output logic              aso_out0_valid,
    output logic              aso_out0_startofpacket,
    output logic              aso_out0_endofpacket,
    output logic              cp_active,
    output logic              err_framing
);

    localparam logic [ADDR_W-1:0] PTR_LAST = ADDR_W'(N_FFT - 1);
    localparam logic [ADDR_W-1:0] PTR_CP0  = ADDR_W'(N_FFT - CP_LEN);
    localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CP   = 2'd1,
        S_BODY = 2'd2
    } state_e;

    typedef struct packed {
        logic valid;
        logic sop;
        logic eop;
        logic cp;
    } tag_t;

    logic              run_q, run_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic              wr_bank_q, wr_bank_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic              rd_bank_q, rd_bank_d;
    logic [1:0]        bank_full_q, bank_full_d;
    state_e            state_q, state_d;
    logic              err_q, err_d;
    tag_t              tag_q [RAM_LAT];
    tag_t              tag_d [RAM_LAT];

    logic              in_ready_c;
    logic              wr_en_c;
    logic [ADDR_W-1:0] wr_addr_ptr_c;
    logic [ADDR_W-1:0] eff_ptr_c;
    logic              keep_c;
    logic              wr_done_c;
    logic              adv_c;
    logic              rd_release_c;
    tag_t              issue_c;

    // Write side: framing checks and bank fill; run_q keeps everything quiet in the first cycle after reset.
    always_comb begin
        run_d         = 1'b1;
        wr_ptr_d      = wr_ptr_q;
        wr_bank_d     = wr_bank_q;
        err_d         = 1'b0;
        wr_en_c       = 1'b0;
        wr_done_c     = 1'b0;
        keep_c        = 1'b0;
        eff_ptr_c     = wr_ptr_q;
        wr_addr_ptr_c = wr_ptr_q;
        in_ready_c    = run_q & ~bank_full_q[wr_bank_q];

        if (asi_in0_valid && in_ready_c) begin
            if (asi_in0_startofpacket) begin
                eff_ptr_c = '0;
                keep_c    = 1'b1;
                err_d     = (wr_ptr_q != '0);
            end else if (wr_ptr_q == '0) begin
                err_d = 1'b1;
            end else begin
                keep_c = 1'b1;
            end

            if (keep_c) begin
                wr_en_c       = 1'b1;
                wr_addr_ptr_c = eff_ptr_c;
                if (eff_ptr_c == PTR_LAST) begin
                    wr_done_c = 1'b1;
                    wr_bank_d = ~wr_bank_q;
                    wr_ptr_d  = '0;
                    if (!asi_in0_endofpacket) begin
                        err_d = 1'b1;
                    end
                end else if (asi_in0_endofpacket) begin
                    err_d    = 1'b1;
                    wr_ptr_d = '0;
                end else begin
                    wr_ptr_d = eff_ptr_c + PTR_ONE;
                end
            end
        end
    end

    // Read issue FSM: prefix words first, then the full body, chained across banks without gaps.
    always_comb begin
        state_d      = state_q;
        rd_ptr_d     = rd_ptr_q;
        rd_bank_d    = rd_bank_q;
        rd_release_c = 1'b0;
        issue_c      = '0;
        adv_c        = run_q & ~(tag_q[RAM_LAT-1].valid & ~aso_out0_ready);

        case (state_q)
            S_CP: begin
                issue_c.valid = 1'b1;
                issue_c.cp    = 1'b1;
                issue_c.sop   = (rd_ptr_q == PTR_CP0);
            end
            S_BODY: begin
                issue_c.valid = 1'b1;
                issue_c.eop   = (rd_ptr_q == PTR_LAST);
            end
            default: ;
        endcase

        if (adv_c) begin
            case (state_q)
                S_IDLE: begin
                    rd_ptr_d = '0;
                    if (bank_full_q[rd_bank_q]) begin
                        state_d  = S_CP;
                        rd_ptr_d = PTR_CP0;
                    end
                end
                S_CP: begin
                    if (rd_ptr_q == PTR_LAST) begin
                        state_d  = S_BODY;
                        rd_ptr_d = '0;
                    end else begin
                        rd_ptr_d = rd_ptr_q + PTR_ONE;
                    end
                end
                S_BODY: begin
                    if (rd_ptr_q == PTR_LAST) begin
                        rd_release_c = 1'b1;
                        rd_bank_d    = ~rd_bank_q;
                        if (bank_full_q[~rd_bank_q]) begin
                            state_d  = S_CP;
                            rd_ptr_d = PTR_CP0;
                        end else begin
                            state_d  = S_IDLE;
                            rd_ptr_d = '0;
                        end
                    end else begin
                        rd_ptr_d = rd_ptr_q + PTR_ONE;
                    end
                end
                default: begin
                    state_d  = S_IDLE;
                    rd_ptr_d = '0;
                end
            endcase
        end
    end

    // Reader and writer always own different banks, so both marks can land on the same edge.
    always_comb begin
        bank_full_d = bank_full_q;
        if (rd_release_c) begin
            bank_full_d[rd_bank_q] = 1'b0;
        end
        if (wr_done_c) begin
            bank_full_d[wr_bank_q] = 1'b1;
        end
    end

    // Tag pipeline mirrors the RAM read latency and stalls with it.
    always_comb begin
        for (int unsigned i = 0; i < RAM_LAT; i++) begin
            tag_d[i] = tag_q[i];
        end
        if (adv_c) begin
            tag_d[0] = issue_c;
            for (int unsigned i = 1; i < RAM_LAT; i++) begin
                tag_d[i] = tag_q[i-1];
            end
        end
    end

    always_ff @(posedge clock_clk or negedge reset_reset) begin
        if (!reset_reset) begin
            run_q       <= 1'b0;
            wr_ptr_q    <= '0;
            wr_bank_q   <= 1'b0;
            rd_ptr_q    <= '0;
            rd_bank_q   <= 1'b0;
            bank_full_q <= '0;
            state_q     <= S_IDLE;
            err_q       <= 1'b0;
            for (int unsigned i = 0; i < RAM_LAT; i++) begin
                tag_q[i] <= '0;
            end
        end else begin
            run_q       <= run_d;
            wr_ptr_q    <= wr_ptr_d;
            wr_bank_q   <= wr_bank_d;
            rd_ptr_q    <= rd_ptr_d;
            rd_bank_q   <= rd_bank_d;
            bank_full_q <= bank_full_d;
            state_q     <= state_d;
            err_q       <= err_d;
            for (int unsigned i = 0; i < RAM_LAT; i++) begin
                tag_q[i] <= tag_d[i];
            end
        end
    end

    assign asi_in0_ready          = in_ready_c;
    assign ram_wr_en              = wr_en_c;
    assign ram_wr_addr            = {wr_bank_q, wr_addr_ptr_c};
    assign ram_rd_addr            = {rd_bank_q, rd_ptr_q};
    assign ram_rd_ce              = adv_c;
    assign aso_out0_valid         = tag_q[RAM_LAT-1].valid;
    assign aso_out0_startofpacket = tag_q[RAM_LAT-1].sop;
    assign aso_out0_endofpacket   = tag_q[RAM_LAT-1].eop;
    assign cp_active              = tag_q[RAM_LAT-1].cp;
    assign err_framing            = err_q;

endmodule

// File: tb/tb_ofdm_cp_sequencer.sv
// Scoreboard bench for ofdm_cp_sequencer: a symbol-level reference model predicts every output beat
// (with data from a bench-side RAM model) and a monitor pops and compares on each accepted beat.
module tb_ofdm_cp_sequencer;

    localparam int N   = 1024;
    localparam int CP  = 128;
    localparam int AW  = 10;
    localparam int LAT = 2;
    localparam int DW  = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          asi_valid, asi_sop, asi_eop, asi_ready;
    logic          ram_wr_en, ram_rd_ce;
    logic [AW:0]   ram_wr_addr, ram_rd_addr;
    logic          aso_ready, aso_valid, aso_sop, aso_eop, cp_act, err_fr;
    logic [DW-1:0] in_data;

    ofdm_cp_sequencer #(.N_FFT(N), .CP_LEN(CP), .ADDR_W(AW), .RAM_LAT(LAT)) dut (
        .clock_clk              (clk),
        .reset_reset            (rst_n),
        .asi_in0_valid          (asi_valid),
        .asi_in0_startofpacket  (asi_sop),
        .asi_in0_endofpacket    (asi_eop),
        .asi_in0_ready          (asi_ready),
        .ram_wr_en              (ram_wr_en),
        .ram_wr_addr            (ram_wr_addr),
        .ram_rd_addr            (ram_rd_addr),
        .ram_rd_ce              (ram_rd_ce),
        .aso_out0_ready         (aso_ready),
        .aso_out0_valid         (aso_valid),
        .aso_out0_startofpacket (aso_sop),
        .aso_out0_endofpacket   (aso_eop),
        .cp_active              (cp_act),
        .err_framing            (err_fr)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // External simple-dual-port RAM with a ce-gated read pipeline.
    logic [DW-1:0] mem [2*N];
    logic [DW-1:0] rq  [LAT];
    always @(posedge clk) begin
        if (ram_wr_en) mem[ram_wr_addr] <= in_data;
        if (ram_rd_ce) begin
            rq[0] <= mem[ram_rd_addr];
            for (int i = 1; i < LAT; i++) rq[i] <= rq[i-1];
        end
    end

    typedef struct {
        logic [DW-1:0] d;
        logic          sop;
        logic          eop;
        logic          cp;
    } exp_t;

    exp_t          exp_q[$];
    logic [DW-1:0] cur[$];
    int            n_checks = 0;
    int            n_fail   = 0;
    int            err_exp  = 0;
    int            err_seen = 0;
    int            last_acc = 0;
    bit            rand_ready = 1'b0;
    bit            lat_armed  = 1'b0;
    int            lat_exp    = 0;
    bit            gap_mode   = 1'b0;
    int            gap_first  = -1;
    int            gap_last   = -1;
    int            gap_beats  = 0;
    bit            prev_stall = 1'b0;
    logic [AW:0]   prev_addr;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
        end
    endfunction

    // A completed symbol replays its last CP words, then every word in order.
    function automatic void push_symbol();
        exp_t e;
        for (int k = 0; k < N + CP; k++) begin
            e.d   = (k < CP) ? cur[N - CP + k] : cur[k - CP];
            e.sop = (k == 0);
            e.eop = (k == N + CP - 1);
            e.cp  = (k < CP);
            exp_q.push_back(e);
        end
    endfunction

    // Symbol-level framing rules applied to each accepted input beat.
    function automatic void model_beat(logic [DW-1:0] d, logic sop, logic eop);
        if (sop) begin
            if (cur.size() != 0) err_exp++;
            cur.delete();
            cur.push_back(d);
        end else if (cur.size() == 0) begin
            err_exp++;
            return;
        end else begin
            cur.push_back(d);
        end
        if (cur.size() == N) begin
            if (!eop) err_exp++;
            push_symbol();
            cur.delete();
        end else if (eop) begin
            err_exp++;
            cur.delete();
        end
    endfunction

    // Monitor: error pulse counting, stall stability and scoreboard compare.
    always @(negedge clk) begin
        if (rst_n) begin
            if (err_fr) err_seen++;
            if (prev_stall) chk("rd_addr_stall", 32'(ram_rd_addr), 32'(prev_addr));
            if (aso_valid && aso_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_beat", 32'(rq[LAT-1]), 32'hFFFF_FFFF);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("beat", 32'({rq[LAT-1], aso_sop, aso_eop, cp_act}),
                                32'({e.d, e.sop, e.eop, e.cp}));
                end
                if (lat_armed && aso_sop) begin
                    chk("first_valid_cycle", 32'(cyc), 32'(lat_exp));
                    lat_armed = 1'b0;
                end
                if (gap_mode) begin
                    if (aso_sop && gap_first < 0) gap_first = cyc;
                    if (aso_eop) gap_last = cyc;
                    gap_beats++;
                end
            end
            prev_stall = aso_valid && !aso_ready;
            prev_addr  = ram_rd_addr;
        end else begin
            prev_stall = 1'b0;
        end
    end

    initial begin
        aso_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1 aso_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    task automatic send(logic [DW-1:0] d, logic sop, logic eop);
        int g = 0;
        asi_valid = 1'b1;
        in_data   = d;
        asi_sop   = sop;
        asi_eop   = eop;
        while (!asi_ready && g < 20000) begin
            @(negedge clk);
            g++;
        end
        if (!asi_ready) begin
            chk("in_ready_timeout", 32'(asi_ready), 32'd1);
            asi_valid = 1'b0;
            return;
        end
        @(posedge clk);
        model_beat(d, sop, eop);
        @(negedge clk);
        last_acc  = cyc;
        asi_valid = 1'b0;
    endtask

    task automatic send_sym(int n, bit eop_last, bit idx_data, bit gaps, bit arm);
        for (int i = 0; i < n; i++) begin
            send(idx_data ? DW'(i) : DW'($urandom), i == 0, eop_last && (i == n - 1));
            if (gaps && ($urandom_range(0, 7) == 0)) repeat ($urandom_range(1, 3)) @(negedge clk);
        end
        if (arm) begin
            lat_exp   = last_acc + 1 + LAT;
            lat_armed = 1'b1;
        end
    endtask

    task automatic drain(string name);
        int g = 0;
        while (exp_q.size() != 0 && g < 30000) begin
            @(negedge clk);
            g++;
        end
        chk({name, "_drain"}, 32'(exp_q.size()), 32'd0);
        repeat (8) @(negedge clk);
        chk({name, "_err_count"}, 32'(err_seen), 32'(err_exp));
        chk({name, "_latency_seen"}, 32'(lat_armed), 32'd0);
        lat_armed = 1'b0;
    endtask

    task automatic check_reset_outs(string name);
        chk({name, "_in_ready"}, 32'(asi_ready), 32'd0);
        chk({name, "_wr_en"},    32'(ram_wr_en), 32'd0);
        chk({name, "_wr_addr"},  32'(ram_wr_addr), 32'd0);
        chk({name, "_rd_addr"},  32'(ram_rd_addr), 32'd0);
        chk({name, "_rd_ce"},    32'(ram_rd_ce), 32'd0);
        chk({name, "_valid"},    32'(aso_valid), 32'd0);
        chk({name, "_sop"},      32'(aso_sop), 32'd0);
        chk({name, "_eop"},      32'(aso_eop), 32'd0);
        chk({name, "_cp"},       32'(cp_act), 32'd0);
        chk({name, "_err"},      32'(err_fr), 32'd0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int g;
        asi_valid = 1'b0;
        asi_sop   = 1'b0;
        asi_eop   = 1'b0;
        in_data   = '0;
        rst_n     = 1'b0;
        #1 check_reset_outs("reset");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // T1: single symbol, data = address, continuous output
        send_sym(N, 1'b1, 1'b1, 1'b0, 1'b1);
        drain("t1");

        // T2: three back-to-back symbols with continuous input
        gap_mode = 1'b1;
        for (int s = 0; s < 3; s++) send_sym(N, 1'b1, 1'b0, 1'b0, 1'b0);
        drain("t2");
        gap_mode = 1'b0;
        chk("t2_beats", 32'(gap_beats), 32'(3 * (N + CP)));
        chk("t2_span",  32'(gap_last - gap_first), 32'(3 * (N + CP) - 1));

        // T3: random downstream ready, plus random input gaps
        rand_ready = 1'b1;
        send_sym(N, 1'b1, 1'b1, 1'b0, 1'b0);
        send_sym(N, 1'b1, 1'b0, 1'b1, 1'b0);
        drain("t3");
        rand_ready = 1'b0;

        // T4: early EOP discards the symbol; the next good one is intact
        send_sym(501, 1'b1, 1'b0, 1'b0, 1'b0);
        send_sym(N, 1'b1, 1'b0, 1'b0, 1'b0);
        drain("t4");

        // T5: SOP mid-symbol restarts at address 0
        send_sym(300, 1'b0, 1'b0, 1'b0, 1'b0);
        send_sym(N, 1'b1, 1'b0, 1'b0, 1'b0);
        drain("t5");

        // Missing SOP drops words; missing final EOP keeps the symbol
        for (int i = 0; i < 3; i++) send(DW'($urandom), 1'b0, 1'b0);
        send_sym(N, 1'b0, 1'b0, 1'b1, 1'b0);
        drain("frame_edges");

        // T6: asynchronous reset during CP replay, then normal recovery
        send_sym(N, 1'b1, 1'b0, 1'b0, 1'b0);
        g = 0;
        while (!(aso_valid && cp_act) && g < 5000) begin
            @(negedge clk);
            g++;
        end
        chk("t6_reached_cp", 32'(aso_valid && cp_act), 32'd1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 check_reset_outs("t6_reset");
        exp_q.delete();
        cur.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send_sym(N, 1'b1, 1'b0, 1'b1, 1'b1);
        drain("t6");

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule
